// File: rtl/wide_add_sequencer.sv
// Multi-word add sequencer: slices wide operands into WIDTH-bit words and chains them
// through one external registered adder. Optional `out_ovf` port under WIDE_ADD_OVF_EN.
module wide_add_sequencer #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*WORDS-1:0]   in_a,
    input  logic [WIDTH*WORDS-1:0]   in_b,
    input  logic                     in_ci,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*WORDS-1:0]   out_s,
    output logic                     out_co,
`ifdef WIDE_ADD_OVF_EN
    output logic                     out_ovf,
`endif
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_ci,
    input  logic [WIDTH-1:0]         add_s,
    input  logic                     add_co
);

    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COLLECT,
        DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [KW-1:0]                 k_q, k_d;
    logic [WORDS-1:0][WIDTH-1:0]   a_q, a_d;
    logic [WORDS-1:0][WIDTH-1:0]   b_q, b_d;
    logic [WORDS-1:0][WIDTH-1:0]   sum_q, sum_d;
    logic                          carry_q, carry_d;
    logic                          co_q, co_d;
    logic                          last_word;
`ifdef WIDE_ADD_OVF_EN
    logic                          ovf_q, ovf_d;
`endif

    assign last_word = (k_q == KW'(WORDS - 1));

    // NOTE: every signal written below gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        co_d      = co_q;
`ifdef WIDE_ADD_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_ci    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_ci;
                    k_d     = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                add_a   = a_q[k_q];
                add_b   = b_q[k_q];
                add_ci  = carry_q;
                state_d = COLLECT;
            end
            COLLECT: begin
                // Adder inputs are held a second cycle so its registered output
                // reflects this word at the collect edge.
                add_a      = a_q[k_q];
                add_b      = b_q[k_q];
                add_ci     = carry_q;
                sum_d[k_q] = add_s;
                carry_d    = add_co;
                if (last_word) begin
                    co_d    = add_co;
`ifdef WIDE_ADD_OVF_EN
                    ovf_d   = (a_q[WORDS-1][WIDTH-1] == b_q[WORDS-1][WIDTH-1]) &&
                              (add_s[WIDTH-1] != a_q[WORDS-1][WIDTH-1]);
`endif
                    state_d = DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = ISSUE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: operand and result registers are reset along with the FSM so an abandoned
    // transaction leaves nothing visible on out_s/out_co.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so all registers sample the same pre-edge values.
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
`ifdef WIDE_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign out_s  = sum_q;
    assign out_co = co_q;
`ifdef WIDE_ADD_OVF_EN
    assign out_ovf = ovf_q;
`endif

endmodule
